regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file for the RISC-V pipeline, generalising the single-write/two-read file to NRD read ports and two write ports. It adds same-cycle write-to-read bypass, a hardwired-zero x0 option, write-port priority, and a sequential clear engine that zeroes the array after reset or on request. It sits between decode (read ports) and writeback (write ports), and writes on the rising clock edge.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- AW, 5, address width, equal to log2(NREGS)
- NRD, 2, number of read ports, 1 to 4
- ZERO_X0, 1, when 1 register 0 always reads 0 and writes to it are dropped
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]; combinational
- wr0_en, wr0_addr, wr0_data  in  1 / AW / XLEN  write port 0
- wr1_en, wr1_addr, wr1_data  in  1 / AW / XLEN  write port 1; has priority over port 0
- clear_req  in  1  single-cycle pulse that requests a full array clear
- busy  out  1  high while the clear engine is running; registered

## Operation
- FSM states: INIT and RUN. A clear pointer `ptr` is AW+1 bits wide.
- rst=1 at an edge: state goes to INIT and ptr goes to 0. The array is not modified at that edge. Holding rst keeps ptr at 0.
- INIT, rst=0: at each edge, regs[ptr] is set to 0 and ptr increments. At the edge that clears register NREGS-1, state goes to RUN. INIT therefore lasts exactly NREGS cycles after rst is released.
- INIT: both write ports are ignored. Writes are not queued; the caller must wait for busy=0.
- INIT: every rd_data port outputs 0.
- RUN, clear_req=1: state goes to INIT and ptr goes to 0. Any writes presented in that same cycle are still committed. Because the clear then runs, their effect is lost.
- clear_req during INIT is ignored and does not restart the clear.
- rst has priority over clear_req.
- Write commit (RUN only): port k commits when wrk_en=1, unless ZERO_X0=1 and wrk_addr=0.
- If both ports commit to the same address, wr1_data is stored and wr0 is discarded.
- If the ports target different addresses, both are stored at the same edge.
- Read, RUN:
  - If ZERO_X0=1 and the address is 0, the result is 0.
  - Otherwise, if BYPASS=1 and a committing write port matches the address, the result is that port's data, with wr1 taking precedence over wr0.
  - Otherwise the result is regs[addr].
- BYPASS=0: a read returns the pre-edge value, and the written value appears from the next cycle.
- Read ports are independent. Any number of ports may read the same address.
- All address bits are used. No out-of-range address exists because NREGS = 2^AW.

## Timing
- Write latency is 1 edge. Read latency is 0 (combinational from rd_addr, array, and write ports).
- Bypass path: wr*_en/addr/data to rd_data is combinational. This is a critical path and is checked in synthesis.
- busy is 1 from the first edge with rst=1 through the edge that clears the last register. It is 0 in the following cycle.
- Power-up before the first rst: busy and the array contents are undefined. A bench must apply rst before any check.
- Reset values: busy=1, state=INIT, ptr=0, rd_data=0 (forced in INIT). The array is all zero after NREGS clear cycles, not at the reset edge.
- rst asserted mid-INIT: the next edge returns ptr to 0, and the full NREGS-cycle clear reruns after release.
- rst asserted in RUN concurrently with writes: the writes are dropped.

## Test plan
- Reset clear: preload the array through writes, assert rst for 3 cycles, then release. Required: busy=1 for exactly 32 cycles after release, every read returns 0 during that time, and all 32 registers read 0 once busy=0.
- Basic write/read (BYPASS=0): write x5=0xDEADBEEF at cycle t. Required: port 0 reads the old value at t and 0xDEADBEEF at t+1. Port 1 reading x5 at t+1 also returns 0xDEADBEEF.
- Dual write collision: wr0 x7=0x11111111 and wr1 x7=0x22222222 in the same cycle, plus a second case with wr0 x3=0xA and wr1 x4=0xB. Required: x7 reads 0x22222222. x3 reads 0xA and x4 reads 0xB.
- Bypass (BYPASS=1): read x9 while wr0 writes x9=0x1234 in the same cycle. Required: rd_data=0x1234 in that cycle. With both ports writing x9 (0x1234 on wr0, 0x5678 on wr1), required: 0x5678.
- x0 behaviour (ZERO_X0=1): wr1 writes x0=0xFFFFFFFF, with BYPASS=1 and a same-cycle read of x0. Required: 0 in that cycle and in every later cycle.
- clear_req and reset mid-clear: in RUN, pulse clear_req with a concurrent write x2=0x55. Required: busy=1 for 32 cycles, then x2 reads 0, and a clear_req at INIT cycle 10 has no effect. Separately, assert rst at INIT cycle 10. Required: busy stays 1 for a full 32 cycles after rst is released.

Source files
------------

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port integer register file with two write ports, optional
//            write-to-read bypass, hardwired x0 and a sequential clear engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_X0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                clear_req,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_ptr;
    logic [AW:0]     w_ptr_nxt;
    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr0_commit;
    logic            w_wr1_commit;

    // A write commits only in RUN; reset in the same cycle drops it.
    assign w_wr0_commit = !rst && (r_state == ST_RUN) && wr0_en &&
                          !((ZERO_X0 != 0) && (wr0_addr == '0));
    assign w_wr1_commit = !rst && (r_state == ST_RUN) && wr1_en &&
                          !((ZERO_X0 != 0) && (wr1_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_INIT: begin
                w_ptr_nxt = r_ptr + (AW+1)'(1);
                if (r_ptr == (AW+1)'(NREGS-1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt = ST_INIT;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_INIT)) begin
            r_regs[r_ptr[AW-1:0]] <= '0;
        end
        if (w_wr0_commit) begin
            r_regs[wr0_addr] <= wr0_data;
        end
        if (w_wr1_commit) begin
            r_regs[wr1_addr] <= wr1_data;
        end
    end

    assign busy = (r_state == ST_INIT);

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_val;

            assign w_addr = rd_addr[gi*AW +: AW];

            always_comb begin
                w_val = r_regs[w_addr];
                if ((BYPASS != 0) && w_wr0_commit && (wr0_addr == w_addr)) begin
                    w_val = wr0_data;
                end
                if ((BYPASS != 0) && w_wr1_commit && (wr1_addr == w_addr)) begin
                    w_val = wr1_data;
                end
                if ((ZERO_X0 != 0) && (w_addr == '0)) begin
                    w_val = '0;
                end
                if (r_state != ST_RUN) begin
                    w_val = '0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = w_val;
        end
    endgenerate

endmodule

`default_nettype wire
